// File: rtl/incubator_thermal_model_if.sv
// Controller <-> thermal plant signal bundle.
// The controller drives commands and load; the plant returns temperature and status.
interface incubator_thermal_model_if;
    logic       Heater;
    logic       Cooler;
    logic       load;
    logic [7:0] load_T;
    logic [7:0] T;
    logic       tick;
    logic       fault;

    modport master (
        output Heater, Cooler, load, load_T,
        input  T, tick, fault
    );

    modport slave (
        input  Heater, Cooler, load, load_T,
        output T, tick, fault
    );
endinterface

// File: rtl/incubator_thermal_model.sv
// Incubator chamber thermal plant emulator: heats, cools, drifts toward ambient
// and saturates, updating once per prescaler period; load forces a temperature.
module incubator_thermal_model #(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned HEAT_STEP   = 1,
    parameter int unsigned COOL_STEP   = 1,
    parameter int unsigned DRIFT_TICKS = 4,
    parameter int unsigned AMBIENT     = 22,
    parameter int unsigned T_INIT      = 22,
    parameter int unsigned T_MIN       = 0,
    parameter int unsigned T_MAX       = 60
) (
    input logic                      clk,
    input logic                      rstN,
    incubator_thermal_model_if.slave bus
);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned DW = (DRIFT_TICKS > 1) ? $clog2(DRIFT_TICKS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DRIFT_TICKS - 1);

    // 10-bit arithmetic keeps sums and differences from wrapping before the clamp
    localparam logic [9:0] HSTEP10    = 10'(HEAT_STEP);
    localparam logic [9:0] TMAX10     = 10'(T_MAX);
    localparam logic [9:0] COOL_FLOOR = 10'(T_MIN) + 10'(COOL_STEP);
    localparam logic [7:0] CSTEP8     = 8'(COOL_STEP);
    localparam logic [7:0] TMIN8      = 8'(T_MIN);
    localparam logic [7:0] TMAX8      = 8'(T_MAX);
    localparam logic [7:0] AMB8       = 8'(AMBIENT);
    localparam logic [7:0] TINIT8     = 8'(T_INIT);

    logic [CW-1:0] cnt;
    logic [DW-1:0] dcnt;
    logic [7:0]    temp;
    logic          tick_r;
    logic          fault_r;

    logic [9:0] heat_sum;
    logic [7:0] heat_t;
    logic [7:0] cool_t;
    logic [7:0] drift_t;
    logic [7:0] load_t;

    always_comb begin
        heat_sum = {2'b00, temp} + HSTEP10;
        heat_t   = (heat_sum >= TMAX10) ? TMAX8 : heat_sum[7:0];
        cool_t   = ({2'b00, temp} <= COOL_FLOOR) ? TMIN8 : (temp - CSTEP8);

        if (temp > AMB8) begin
            drift_t = temp - 8'd1;
        end else if (temp < AMB8) begin
            drift_t = temp + 8'd1;
        end else begin
            drift_t = temp;
        end

        if (bus.load_T >= TMAX8) begin
            load_t = TMAX8;
        end else if (bus.load_T <= TMIN8) begin
            load_t = TMIN8;
        end else begin
            load_t = bus.load_T;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt     <= '0;
            dcnt    <= '0;
            temp    <= TINIT8;
            tick_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (bus.load) begin
                // Load wins over a coincident update and restarts the prescaler
                temp    <= load_t;
                cnt     <= '0;
                dcnt    <= '0;
                fault_r <= 1'b0;
                tick_r  <= 1'b1;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                tick_r <= 1'b1;
                case ({bus.Heater, bus.Cooler})
                    2'b10: begin
                        temp <= heat_t;
                        dcnt <= '0;
                    end
                    2'b01: begin
                        temp <= cool_t;
                        dcnt <= '0;
                    end
                    2'b11: begin
                        fault_r <= 1'b1;
                        dcnt    <= '0;
                    end
                    default: begin
                        if (dcnt == DCNT_LAST) begin
                            dcnt <= '0;
                            temp <= drift_t;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                endcase
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.T     = temp;
    assign bus.tick  = tick_r;
    assign bus.fault = fault_r;
endmodule

// File: tb/tb_incubator_thermal_model.sv
// Bench for incubator_thermal_model: per-cycle scoreboard from a behavioural
// plant model plus directed temperature checks along the lab scenarios.
module tb_incubator_thermal_model;
    logic clk;
    logic rstN;

    incubator_thermal_model_if bus ();

    incubator_thermal_model #(
        .TICK_DIV    (4),
        .HEAT_STEP   (1),
        .COOL_STEP   (2),
        .DRIFT_TICKS (4),
        .AMBIENT     (22),
        .T_INIT      (22),
        .T_MIN       (0),
        .T_MAX       (60)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [7:0] t;
        logic       tick;
        logic       fault;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Behavioural plant model, integer arithmetic with explicit clamps
    int m_t, m_cnt, m_dcnt;
    bit m_fault, m_tick;
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_t = 22; m_cnt = 0; m_dcnt = 0; m_fault = 0;
            sb.delete();
        end else begin
            m_tick = 0;
            if (bus.load) begin
                m_t = (int'(bus.load_T) > 60) ? 60 : int'(bus.load_T);
                m_cnt = 0; m_dcnt = 0; m_fault = 0; m_tick = 1;
            end else if (m_cnt == 3) begin
                m_cnt = 0; m_tick = 1;
                if (bus.Heater && !bus.Cooler) begin
                    m_t = m_t + 1; if (m_t > 60) m_t = 60; m_dcnt = 0;
                end else if (!bus.Heater && bus.Cooler) begin
                    m_t = m_t - 2; if (m_t < 0) m_t = 0; m_dcnt = 0;
                end else if (bus.Heater && bus.Cooler) begin
                    m_fault = 1; m_dcnt = 0;
                end else begin
                    m_dcnt = m_dcnt + 1;
                    if (m_dcnt == 4) begin
                        m_dcnt = 0;
                        if (m_t > 22) m_t = m_t - 1;
                        else if (m_t < 22) m_t = m_t + 1;
                    end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            sb.push_back('{t: 8'(m_t), tick: m_tick, fault: m_fault});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstN && sb.size() > 0) begin
            e = sb.pop_front();
            check_val("sb_T", int'(bus.T), int'(e.t));
            check_val("sb_tick", int'(bus.tick), int'(e.tick));
            check_val("sb_fault", int'(bus.fault), int'(e.fault));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the load edge
    task automatic do_load(input logic [7:0] v);
        bus.load   = 1'b1;
        bus.load_T = v;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Heater = 1'b0;
        bus.Cooler = 1'b0;
        bus.load   = 1'b0;
        bus.load_T = 8'd0;
        rstN = 1'b1;
        #2 rstN = 1'b0;
        #5;
        check_val("rst_T", int'(bus.T), 22);
        check_val("rst_tick", int'(bus.tick), 0);
        check_val("rst_fault", int'(bus.fault), 0);
        @(negedge clk);
        rstN = 1'b1;

        // Idle at ambient: T holds, tick every 4th cycle
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            check_val("idle_T", int'(bus.T), 22);
            check_val("idle_fault", int'(bus.fault), 0);
            check_val("idle_tick", int'(bus.tick), (i % 4 == 0) ? 1 : 0);
        end

        // Heating from reset, then asynchronous reset mid-run
        rstN = 1'b0;
        bus.Heater = 1'b1;
        @(negedge clk);
        rstN = 1'b1;
        cyc(4);
        check_val("heat_T4", int'(bus.T), 23);
        check_val("heat_tick4", int'(bus.tick), 1);
        cyc(4);
        check_val("heat_T8", int'(bus.T), 24);
        check_val("heat_tick8", int'(bus.tick), 1);
        cyc(1);
        @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        check_val("arst_T", int'(bus.T), 22);
        check_val("arst_tick", int'(bus.tick), 0);
        bus.Heater = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        cyc(1);

        // Saturation at T_MAX and load clamp
        do_load(8'd59);
        check_val("load59", int'(bus.T), 59);
        bus.Heater = 1'b1;
        cyc(4);
        check_val("sat_hi", int'(bus.T), 60);
        cyc(8);
        check_val("sat_hi_hold", int'(bus.T), 60);
        do_load(8'd70);
        check_val("load70_clamp", int'(bus.T), 60);
        bus.Heater = 1'b0;
        do_load(8'd1);
        check_val("load1", int'(bus.T), 1);
        bus.Cooler = 1'b1;
        cyc(4);
        check_val("sat_lo", int'(bus.T), 0);
        cyc(8);
        check_val("sat_lo_hold", int'(bus.T), 0);
        bus.Cooler = 1'b0;

        // Conflict: hold T, sticky fault until load
        do_load(8'd30);
        bus.Heater = 1'b1;
        bus.Cooler = 1'b1;
        cyc(4);
        check_val("conf_T", int'(bus.T), 30);
        check_val("conf_fault", int'(bus.fault), 1);
        bus.Cooler = 1'b0;
        cyc(4);
        check_val("conf_heat_T", int'(bus.T), 31);
        check_val("conf_sticky", int'(bus.fault), 1);
        do_load(8'd30);
        check_val("conf_clear", int'(bus.fault), 0);
        bus.Heater = 1'b0;

        // Drift toward ambient
        do_load(8'd26);
        cyc(16);
        check_val("drift_25", int'(bus.T), 25);
        cyc(16);
        check_val("drift_24", int'(bus.T), 24);
        cyc(32);
        check_val("drift_22", int'(bus.T), 22);
        cyc(16);
        check_val("drift_hold", int'(bus.T), 22);

        // One heating update restarts the drift count
        do_load(8'd26);
        cyc(8);
        bus.Heater = 1'b1;
        cyc(4);
        check_val("drift_heat", int'(bus.T), 27);
        bus.Heater = 1'b0;
        cyc(12);
        check_val("drift_restart", int'(bus.T), 27);
        cyc(4);
        check_val("drift_after", int'(bus.T), 26);

        // Load colliding with an update edge
        do_load(8'd20);
        bus.Heater = 1'b1;
        cyc(3);
        do_load(8'd40);
        check_val("coll_T", int'(bus.T), 40);
        check_val("coll_tick", int'(bus.tick), 1);
        cyc(4);
        check_val("coll_next", int'(bus.T), 41);

        // Held load keeps reloading and parks the prescaler
        bus.load   = 1'b1;
        bus.load_T = 8'd35;
        cyc(6);
        check_val("held_T", int'(bus.T), 35);
        bus.load = 1'b0;
        cyc(3);
        check_val("held_pre", int'(bus.T), 35);
        cyc(1);
        check_val("held_post", int'(bus.T), 36);
        bus.Heater = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/incubator_thermal_model.md
# incubator_thermal_model

Synthesizable thermal plant emulator for the incubator lab setup. It closes the loop around the incubator power controller. It consumes the controller's `Heater`/`Cooler` commands and produces the 8-bit chamber temperature `T` that the controller reads. Temperature moves at parameterized rates, saturates at physical limits and drifts toward ambient when idle. A load port injects disturbances, such as a door opening.

## Interface
Parameters:
- `TICK_DIV`, 1000: clock cycles per plant update (≥2)
- `HEAT_STEP`, 1: °C added per update while heating
- `COOL_STEP`, 1: °C removed per update while cooling
- `DRIFT_TICKS`, 4: idle updates per 1 °C drift toward ambient (≥1)
- `AMBIENT`, 22: drift target, °C
- `T_INIT`, 22: temperature after reset
- `T_MIN`, 0 / `T_MAX`, 60: saturation limits (T_MIN ≤ AMBIENT, T_INIT ≤ T_MAX)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rstN` in 1: asynchronous, active-low reset
- `Heater` in 1: heater command from controller
- `Cooler` in 1: cooler command from controller
- `load` in 1: synchronous disturbance strobe
- `load_T` in 8: temperature forced on `load`
- `T` out 8: current chamber temperature, registered
- `tick` out 1: one-cycle pulse, high in the first cycle a new `T` is visible
- `fault` out 1: sticky; Heater and Cooler were both asserted at an update

## Operation
- Prescaler `cnt` counts 0..TICK_DIV-1. The edge where `cnt==TICK_DIV-1` is the **update edge**; `cnt` returns to 0 on that edge.
- Mode is decoded from `Heater`/`Cooler` sampled at the update edge:
  - HEAT (H=1, C=0): `T <= min(T+HEAT_STEP, T_MAX)`; drift counter cleared.
  - COOL (H=0, C=1): `T <= max(T-COOL_STEP, T_MIN)`; drift counter cleared.
  - CONFLICT (H=1, C=1): T held, `fault <= 1`, drift counter cleared.
  - IDLE (H=0, C=0): the drift counter `dcnt` increments. At `dcnt==DRIFT_TICKS-1`, `dcnt <= 0` and T steps 1 toward AMBIENT; T is unchanged if already equal.
- Arithmetic is done at ≥9 bits so that the sum and difference cannot wrap before the clamp. A result outside [T_MIN, T_MAX] is clamped.
- `tick` asserts after every update edge, including those where T is unchanged.
- Load behaviour (`load=1` at an edge):
  - Highest priority; overrides any update on that same edge.
  - `T <= clamp(load_T, T_MIN, T_MAX)`; `cnt <= 0`, `dcnt <= 0`, `fault <= 0`.
  - `tick` asserts the next cycle.
  - Held `load` reloads every cycle, and the prescaler stays at 0.
- `Heater`/`Cooler` are ignored between update edges; glitches there have no effect.

## Timing
- Reset (async assert, any time including mid-update) gives:
  - `T=T_INIT`, `tick=0`, `fault=0`
  - `cnt=0`, `dcnt=0`
- First update edge is the TICK_DIV-th rising edge after `rstN` deasserts. Updates then follow every TICK_DIV cycles.
- Latency from the update edge:
  - New `T` is visible immediately after that edge.
  - `tick` is high for exactly that following cycle.
- Command-to-temperature latency is at most TICK_DIV cycles: a command change is seen at the next update edge.
- Load latency: `T` shows the loaded value 1 cycle after the strobe edge. The next update is TICK_DIV edges after the load edge.
- `fault` rises with the CONFLICT update edge and stays high until reset or load.
- `T` never leaves [T_MIN, T_MAX], and never changes except on an update or load edge.

## Test plan
Bench parameters: TICK_DIV=4, HEAT_STEP=1, COOL_STEP=2, DRIFT_TICKS=4, AMBIENT=22, T_INIT=22, T_MAX=60.
- Reset/idle: release `rstN` with H=C=0 → `T=22`, `fault=0` for 100 cycles; `tick` pulses every 4 cycles starting on the 4th edge.
- Heating: H=1 from reset → T=23 after edge 4 and T=24 after edge 8, with a `tick` in each of those cycles. Assert `rstN` low at edge 10 → T=22 and `tick=0` immediately.
- Saturation and clamp:
  - load_T=59, then H=1 → T=60 after the next update, and stays 60.
  - load_T=70 → T=60.
  - load_T=1, then C=1 → T=0 (clamped, not 255), and stays 0.
- Conflict: H=C=1 at an update edge with T=30 → T stays 30 and `fault=1`. Then releasing C leaves `fault` set while heating resumes (31). A load strobe clears `fault`.
- Drift: load_T=26 with H=C=0 → T=25 after 16 cycles, 24 after 32, and reaches 22 after 64, then holds. Asserting H for one update mid-sequence restarts the 4-update drift count.
- Load vs update collision: pulse `load` (load_T=40) on an update edge with H=1 → T=40, not 41. The next update is 4 edges later, giving T=41.
